seq_multiplier: RTL and testbench

Unsigned N×N shift-and-add multiplier that drives the team's N-bit ripple-carry adder (`FA`) once per cycle. It produces a 2N-bit product after N iterations. The block sits upstream of the adder: it supplies the operand and carry-in, and it consumes `sum` and `c_out`. It is the first multi-cycle arithmetic unit in the datapath and uses a start/busy/done handshake.

---
 rtl/FA.sv | 27 ++
 rtl/seq_multiplier.sv | 102 ++++++++++
 tb/tb_seq_multiplier.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/FA.sv
// N-bit ripple-carry adder shared by the arithmetic datapath.
// Each bit's carry feeds the next bit, so delay grows linearly with N.
module FA #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out
);

    logic [N:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = c_in;
        for (int i = 0; i < N; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign c_out = carry[N];

endmodule

// File: rtl/seq_multiplier.sv
// Unsigned NxN shift-and-add multiplier, one FA add per cycle.
// Handshake: start accepted in idle, busy for N cycles, then a one-cycle done pulse.
module seq_multiplier #(
    parameter int unsigned N = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int unsigned CountW = $clog2(N + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e              state_q, state_d;
    logic [N-1:0]        m_q, m_d;
    logic [N-1:0]        a_q, a_d;
    logic [N-1:0]        q_q, q_d;
    logic [CountW-1:0]   count_q, count_d;
    logic [2*N-1:0]      product_q, product_d;

    logic [N-1:0]        add_b;
    logic [N-1:0]        add_sum;
    logic                add_cout;
    logic [2*N-1:0]      shifted;

    assign add_b = q_q[0] ? m_q : '0;

    FA #(.N(N)) u_fa (
        .a     (a_q),
        .b     (add_b),
        .c_in  (1'b0),
        .sum   (add_sum),
        .c_out (add_cout)
    );

    // Carry-out becomes the new MSB of A; the consumed Q[0] drops off the bottom.
    assign shifted = {add_cout, add_sum, q_q[N-1:1]};

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        a_d       = a_q;
        q_d       = q_q;
        count_d   = count_q;
        product_d = product_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    m_d       = multiplicand;
                    q_d       = multiplier;
                    a_d       = '0;
                    count_d   = CountW'(N);
                    product_d = '0;
                    state_d   = StRun;
                end
            end
            StRun: begin
                {a_d, q_d} = shifted;
                count_d    = count_q - CountW'(1);
                if (count_q == CountW'(1)) begin
                    product_d = shifted;
                    state_d   = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            m_q       <= '0;
            a_q       <= '0;
            q_q       <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            a_q       <= a_d;
            q_q       <= q_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == StRun);
    assign done    = (state_q == StDone);
    assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed cases plus 1000 random back-to-back multiplies.
// Expected products come from plain 64-bit multiplication of the operands.
module tb_seq_multiplier;

    localparam int unsigned N = 32;

    logic          clk;
    logic          rst;
    logic          start;
    logic [N-1:0]  multiplicand;
    logic [N-1:0]  multiplier;
    logic          busy;
    logic          done;
    logic [2*N-1:0] product;

    int total  = 0;
    int passed = 0;
    int cyc    = 0;

    seq_multiplier #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q);
        return {32'b0, m} * {32'b0, q};
    endfunction

    // Full single operation starting from idle, start pulsed for one cycle.
    task automatic do_mul(input string tag, input logic [31:0] m, input logic [31:0] q);
        int busy_cnt = 0;
        int early_done = 0;
        logic [63:0] exp = ref_mul(m, q);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        step();
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        for (int i = 1; i <= int'(N); i++) begin
            if (busy) busy_cnt++;
            if (done) early_done++;
            step();
        end
        check({tag, " busy cycles"}, 64'(busy_cnt), 64'(N));
        check({tag, " early done"}, 64'(early_done), 64'd0);
        check({tag, " done at N+1"}, 64'(done), 64'd1);
        check({tag, " product"}, product, exp);
        step();
        check({tag, " done falls"}, 64'(done), 64'd0);
        check({tag, " product holds"}, product, exp);
    endtask

    initial begin
        int done_cnt;
        int busy_cnt;
        int prev_acc;
        int acc;
        int waited;
        logic [63:0] seen;
        logic [31:0] rm, rq;

        rst = 1'b1;
        start = 1'b1;
        multiplicand = 32'hFFFF_FFFF;
        multiplier = 32'hFFFF_FFFF;
        step();
        step();
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset product", product, 64'd0);
        rst = 1'b0;
        start = 1'b0;
        step();
        check("idle after reset", 64'(busy), 64'd0);

        do_mul("basic 3x5", 32'd3, 32'd5);
        check("basic literal", product, 64'h0000_0000_0000_000F);
        do_mul("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("max literal", product, 64'hFFFF_FFFE_0000_0001);
        do_mul("zero", 32'd0, 32'hDEAD_BEEF);
        do_mul("ident1", 32'h1234_5678, 32'd1);
        do_mul("ident2", 32'd1, 32'h8000_0000);

        // Start pulse during RUN must be dropped, not queued.
        multiplicand = 32'd7;
        multiplier = 32'd9;
        start = 1'b1;
        step();
        start = 1'b0;
        done_cnt = 0;
        seen = '0;
        for (int i = 1; i <= int'(N) + 8; i++) begin
            if (i == 10) begin
                start = 1'b1;
                multiplicand = 32'd2;
                multiplier = 32'd2;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                done_cnt++;
                seen = product;
            end
            step();
        end
        check("busy-start done count", 64'(done_cnt), 64'd1);
        check("busy-start product", seen, 64'd63);
        check("busy-start not queued", 64'(busy), 64'd0);

        // Reset in cycle 15 of RUN aborts.
        multiplicand = 32'hABCD_0123;
        multiplier = 32'h0000_F00D;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i < 15; i++) step();
        check("pre-abort busy", 64'(busy), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort product", product, 64'd0);
        done_cnt = 0;
        busy_cnt = 0;
        for (int i = 0; i < int'(N) + 8; i++) begin
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            step();
        end
        check("abort no done", 64'(done_cnt), 64'd0);
        check("abort stays idle", 64'(busy_cnt), 64'd0);

        // start held high: back-to-back operations, first a directed pair then random.
        start = 1'b1;
        prev_acc = -1;
        for (int k = 0; k <= 1000; k++) begin
            if (k == 0) begin
                rm = 32'h0001_0000;
                rq = 32'h0001_0000;
            end else begin
                rm = $urandom;
                rq = $urandom;
            end
            multiplicand = rm;
            multiplier = rq;
            acc = cyc;
            if (prev_acc >= 0) check("b2b accept spacing", 64'(acc - prev_acc), 64'(N + 2));
            prev_acc = acc;
            step();
            waited = 0;
            while (!done && waited < int'(N) + 4) begin
                step();
                waited++;
            end
            check("b2b done seen", 64'(done), 64'd1);
            check("b2b product", product, ref_mul(rm, rq));
            if (k == 0) check("b2b literal", product, 64'h0000_0001_0000_0000);
            step();
        end
        start = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
